// File: rtl/avalon_streaming_arbiter.sv
// Packet-locked round-robin arbiter merging NUM_IN Avalon-ST sinks onto one registered
// Avalon-ST source; aso_channel reports which input supplied each beat.
module avalon_streaming_arbiter #(
    parameter int NUM_IN     = 4,
    parameter int DATA_WIDTH = 8,
    localparam int CH_WIDTH  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_IN-1:0]              asi_valid,
    input  logic [NUM_IN*DATA_WIDTH-1:0]   asi_data,
    input  logic [NUM_IN-1:0]              asi_endofpacket,
    output logic [NUM_IN-1:0]              asi_ready,
    output logic                           aso_valid,
    output logic [DATA_WIDTH-1:0]          aso_data,
    output logic                           aso_endofpacket,
    output logic [CH_WIDTH-1:0]            aso_channel,
    input  logic                           aso_ready
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                state_r;
    logic [CH_WIDTH-1:0]   grant_r;
    logic [CH_WIDTH-1:0]   rr_ptr_r;

    logic                  pick_found_s;
    logic [CH_WIDTH-1:0]   pick_idx_s;
    logic                  out_free_s;
    logic                  accept_s;
    logic [DATA_WIDTH-1:0] beat_data_s;
    logic                  beat_eop_s;

    // (base + offset) modulo NUM_IN, for offset in 0..NUM_IN
    function automatic logic [CH_WIDTH-1:0] wrap_index(input logic [CH_WIDTH-1:0] base,
                                                       input int unsigned offset);
        int unsigned sum_v;
        sum_v = 32'(base) + offset;
        if (sum_v >= 32'(NUM_IN)) begin
            sum_v = sum_v - 32'(NUM_IN);
        end else begin
            sum_v = sum_v;
        end
        return CH_WIDTH'(sum_v);
    endfunction

    // Round-robin search starting at rr_ptr for the first requesting input
    always_comb begin
        pick_found_s = 1'b0;
        pick_idx_s   = rr_ptr_r;
        for (int unsigned k = 0; k < 32'(NUM_IN); k++) begin
            if (!pick_found_s && asi_valid[wrap_index(rr_ptr_r, k)]) begin
                pick_found_s = 1'b1;
                pick_idx_s   = wrap_index(rr_ptr_r, k);
            end else begin
                pick_idx_s   = pick_idx_s;
            end
        end
    end

    // Only the locked owner sees ready, and only while the output register can take a beat
    always_comb begin
        asi_ready  = '0;
        out_free_s = !aso_valid || aso_ready;
        if (state_r == ST_LOCKED) begin
            asi_ready[grant_r] = out_free_s;
        end else begin
            asi_ready = '0;
        end
        accept_s    = (state_r == ST_LOCKED) && asi_valid[grant_r] && out_free_s;
        beat_data_s = asi_data[32'(grant_r) * DATA_WIDTH +: DATA_WIDTH];
        beat_eop_s  = asi_endofpacket[grant_r];
    end

    // Arbitration FSM and the one-beat output register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r         <= ST_IDLE;
            grant_r         <= '0;
            rr_ptr_r        <= '0;
            aso_valid       <= 1'b0;
            aso_data        <= '0;
            aso_endofpacket <= 1'b0;
            aso_channel     <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pick_found_s) begin
                        grant_r <= pick_idx_s;
                        state_r <= ST_LOCKED;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOCKED: begin
                    if (accept_s && beat_eop_s) begin
                        state_r  <= ST_IDLE;
                        rr_ptr_r <= wrap_index(grant_r, 32'd1);
                    end else begin
                        state_r  <= ST_LOCKED;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase

            // A new beat overwrites a draining one, so a packet streams at one beat per cycle
            if (accept_s) begin
                aso_valid       <= 1'b1;
                aso_data        <= beat_data_s;
                aso_endofpacket <= beat_eop_s;
                aso_channel     <= grant_r;
            end else if (aso_valid && aso_ready) begin
                aso_valid       <= 1'b0;
            end else begin
                aso_valid       <= aso_valid;
            end
        end
    end

endmodule

// File: tb/tb_avalon_streaming_arbiter.sv
// Scoreboard bench for avalon_streaming_arbiter: packet-level round-robin reference model,
// directed scenarios followed by randomized traffic and backpressure.
module tb_avalon_streaming_arbiter;
    localparam int NUM_IN = 4;
    localparam int DW     = 8;
    localparam int CW     = 2;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          eop;
        logic [CW-1:0] ch;
    } beat_t;

    logic                 clk   = 1'b0;
    logic                 reset = 1'b1;
    logic [NUM_IN-1:0]    asi_valid;
    logic [NUM_IN*DW-1:0] asi_data;
    logic [NUM_IN-1:0]    asi_endofpacket;
    logic [NUM_IN-1:0]    asi_ready;
    logic                 aso_valid;
    logic [DW-1:0]        aso_data;
    logic                 aso_endofpacket;
    logic [CW-1:0]        aso_channel;
    logic                 aso_ready;

    int tests = 0;
    int fails = 0;

    beat_t src_q [NUM_IN][$];
    beat_t exp_q [$];
    beat_t out_log [$];
    logic [NUM_IN-1:0] hold    = '0;
    logic [NUM_IN-1:0] acc_dut = '0;
    int  gap [NUM_IN];
    bit  pause_en   = 1'b0;
    bit  gaps_en    = 1'b0;
    int  ready_mode = 0;

    bit    m_busy      = 1'b0;
    int    m_ptr       = 0;
    int    m_grant     = 0;
    bit    m_out_valid = 1'b0;
    bit    pend_valid  = 1'b0;
    beat_t pend_beat;

    always #5 clk = ~clk;

    avalon_streaming_arbiter #(.NUM_IN(NUM_IN), .DATA_WIDTH(DW)) dut (
        .clk             (clk),
        .reset           (reset),
        .asi_valid       (asi_valid),
        .asi_data        (asi_data),
        .asi_endofpacket (asi_endofpacket),
        .asi_ready       (asi_ready),
        .aso_valid       (aso_valid),
        .aso_data        (aso_data),
        .aso_endofpacket (aso_endofpacket),
        .aso_channel     (aso_channel),
        .aso_ready       (aso_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: packet-level round robin, one-cycle gap after eop, one-deep output stage
    always @(negedge clk) begin
        logic [NUM_IN-1:0] exp_ready;
        logic              acc;
        if (!reset) begin
            m_busy = 1'b0; m_ptr = 0; m_grant = 0; m_out_valid = 1'b0;
            pend_valid = 1'b0; acc_dut = '0;
        end else begin
            acc_dut   = asi_valid & asi_ready;
            exp_ready = '0;
            if (m_busy) exp_ready[m_grant] = !m_out_valid || aso_ready;
            chk("asi_ready", 32'(asi_ready), 32'(exp_ready));
            acc = m_busy && asi_valid[m_grant] && exp_ready[m_grant];
            if (acc) begin
                pend_beat.data = asi_data[m_grant*DW +: DW];
                pend_beat.eop  = asi_endofpacket[m_grant];
                pend_beat.ch   = CW'(m_grant);
                pend_valid     = 1'b1;
            end
            if (acc) m_out_valid = 1'b1;
            else if (m_out_valid && aso_ready) m_out_valid = 1'b0;
            if (m_busy) begin
                if (acc && asi_endofpacket[m_grant]) begin
                    m_busy = 1'b0;
                    m_ptr  = (m_grant + 1) % NUM_IN;
                end
            end else if (asi_valid != '0) begin
                for (int k = 0; k < NUM_IN; k++) begin
                    if (!m_busy && asi_valid[(m_ptr + k) % NUM_IN]) begin
                        m_grant = (m_ptr + k) % NUM_IN;
                        m_busy  = 1'b1;
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        if (reset && pend_valid) begin
            exp_q.push_back(pend_beat);
            pend_valid = 1'b0;
        end
    end

    // Output monitor: pops the scoreboard whenever the DUT presents a beat
    always @(negedge clk) begin
        beat_t got;
        if (!reset) begin
            exp_q.delete();
        end else begin
            chk("aso_valid", 32'(aso_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                chk("aso_data", 32'(aso_data), 32'(exp_q[0].data));
                chk("aso_eop", 32'(aso_endofpacket), 32'(exp_q[0].eop));
                chk("aso_channel", 32'(aso_channel), 32'(exp_q[0].ch));
                if (aso_ready) void'(exp_q.pop_front());
            end
            if (aso_valid && aso_ready) begin
                got.data = aso_data; got.eop = aso_endofpacket; got.ch = aso_channel;
                out_log.push_back(got);
            end
        end
    end

    // Stimulus drivers for all inputs and for aso_ready
    initial begin
        asi_valid = '0; asi_data = '0; asi_endofpacket = '0; aso_ready = 1'b1;
        for (int i = 0; i < NUM_IN; i++) gap[i] = 0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       aso_ready = 1'b1;
                1:       aso_ready = ~aso_ready;
                2:       aso_ready = 1'($urandom_range(0, 1));
                default: aso_ready = 1'b0;
            endcase
            for (int i = 0; i < NUM_IN; i++) begin
                if (!reset) begin
                    src_q[i].delete();
                    gap[i] = 0;
                end else if (acc_dut[i] && src_q[i].size() != 0) begin
                    if (src_q[i][0].eop && gaps_en) gap[i] = $urandom_range(0, 2);
                    void'(src_q[i].pop_front());
                end else if (gap[i] > 0) begin
                    gap[i]--;
                end
                if (src_q[i].size() != 0 && gap[i] == 0 && !hold[i] &&
                    !(pause_en && $urandom_range(0, 3) == 0)) begin
                    asi_valid[i]           = 1'b1;
                    asi_data[i*DW +: DW]   = src_q[i][0].data;
                    asi_endofpacket[i]     = src_q[i][0].eop;
                end else begin
                    asi_valid[i]           = 1'b0;
                    asi_data[i*DW +: DW]   = DW'($urandom);
                    asi_endofpacket[i]     = 1'($urandom);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk); #2;
    endtask

    task automatic send_pkt(input int i, input int n, input int base, input int step);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.data = DW'(base + k * step);
            b.eop  = (k == n - 1);
            b.ch   = CW'(i);
            src_q[i].push_back(b);
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        bit done;
        done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            tick();
            done = (exp_q.size() == 0);
            for (int i = 0; i < NUM_IN; i++) if (src_q[i].size() != 0) done = 1'b0;
        end
        chk({name, " drain"}, 32'(done), 32'd1);
    endtask

    task automatic wait_src(input string name, input int i, input int sz);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 100 && !ok; c++) begin
            tick();
            ok = (src_q[i].size() <= sz);
        end
        chk({name, " wait"}, 32'(ok), 32'd1);
    endtask

    task automatic pulse_reset(input string name);
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        chk({name, " aso_valid"}, 32'(aso_valid), 32'd0);
        chk({name, " asi_ready"}, 32'(asi_ready), 32'd0);
        hold = '0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
    endtask

    task automatic chk_log(input string name, input int exp_ch[$], input int exp_d[$]);
        chk({name, " count"}, 32'(out_log.size()), 32'(exp_ch.size()));
        for (int k = 0; k < exp_ch.size() && k < out_log.size(); k++) begin
            chk({name, " ch"}, 32'(out_log[k].ch), 32'(exp_ch[k]));
            if (exp_d.size() > k) chk({name, " data"}, 32'(out_log[k].data), 32'(exp_d[k]));
        end
    endtask

    initial begin
        int total;
        #1 reset = 1'b0;
        #2;
        chk("reset aso_valid", 32'(aso_valid), 32'd0);
        chk("reset asi_ready", 32'(asi_ready), 32'd0);
        chk("reset aso_data", 32'(aso_data), 32'd0);
        chk("reset aso_eop", 32'(aso_endofpacket), 32'd0);
        chk("reset aso_channel", 32'(aso_channel), 32'd0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;

        // single 3-beat packet on input 0
        tick(); out_log.delete();
        send_pkt(0, 3, 'h11, 'h11);
        wait_drain("single", 100);
        chk_log("single", '{0, 0, 0}, '{'h11, 'h22, 'h33});
        for (int k = 0; k < out_log.size(); k++) chk("single eop", 32'(out_log[k].eop), 32'(k == 2));

        // all four inputs holding 2-beat packets: strict rotation from 0
        pulse_reset("rst1");
        tick(); out_log.delete();
        for (int i = 0; i < NUM_IN; i++) send_pkt(i, 2, 16 * i, 1);
        send_pkt(0, 2, 'h80, 1);
        wait_drain("rotate", 200);
        chk_log("rotate", '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0}, '{0, 1, 16, 17, 32, 33, 48, 49, 'h80, 'h81});

        // toggling backpressure
        ready_mode = 1; out_log.delete();
        send_pkt(1, 5, 'hA0, 1);
        wait_drain("bp", 200);
        chk_log("bp", '{1, 1, 1, 1, 1}, '{'hA0, 'hA1, 'hA2, 'hA3, 'hA4});
        ready_mode = 0;

        // input 1 stalls mid-packet while input 2 waits
        tick(); out_log.delete();
        send_pkt(1, 3, 'hB0, 1);
        wait_src("lock", 1, 2);
        hold[1] = 1'b1;
        send_pkt(2, 1, 'hC0, 1);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("lock ready2", 32'(asi_ready[2]), 32'd0);
        end
        hold[1] = 1'b0;
        wait_drain("lock", 100);
        chk_log("lock", '{1, 1, 1, 2}, '{'hB0, 'hB1, 'hB2, 'hC0});

        // pointer wrap from input 3 to input 0
        tick(); out_log.delete();
        send_pkt(3, 2, 'hD0, 1);
        wait_src("wrap", 3, 1);
        send_pkt(0, 2, 'hE0, 1);
        send_pkt(3, 2, 'hF0, 1);
        wait_drain("wrap", 100);
        chk_log("wrap", '{3, 3, 0, 0, 3, 3}, '{'hD0, 'hD1, 'hE0, 'hE1, 'hF0, 'hF1});

        // reset while a beat is held in the output stage
        ready_mode = 3;
        send_pkt(0, 3, 'h50, 1);
        begin
            bit seen;
            seen = 1'b0;
            for (int c = 0; c < 50 && !seen; c++) begin tick(); seen = aso_valid; end
            chk("midrst held", 32'(seen), 32'd1);
        end
        pulse_reset("midrst");
        ready_mode = 0;
        tick(); out_log.delete();
        send_pkt(2, 2, 'h60, 1);
        wait_drain("postrst", 100);
        chk_log("postrst", '{2, 2}, '{'h60, 'h61});

        // randomized traffic with pauses, gaps and random backpressure
        pause_en = 1'b1; gaps_en = 1'b1; ready_mode = 2;
        tick(); out_log.delete();
        total = 0;
        for (int p = 0; p < 60; p++) begin
            int i, n;
            i = $urandom_range(0, NUM_IN - 1);
            n = $urandom_range(1, 4);
            send_pkt(i, n, $urandom_range(0, 255), 1);
            total += n;
            repeat ($urandom_range(0, 3)) tick();
        end
        wait_drain("random", 4000);
        chk("random beats", 32'(out_log.size()), 32'(total));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
